// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared state encoding and byte-enable legality for the data-memory port
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Bytes may sit anywhere; half-words need an even address, words a word-aligned one.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: ok = 1'b1;
            BE_H0, BE_H1:               ok = ~addr_lo[0];
            BE_W:                       ok = (addr_lo == 2'b00);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response handshake bundle between datapath and data memory
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_store_array.sv
// rtl/dm_store_array.sv - byte-enabled word storage, synchronous write, async clear, combinational read
module dm_store_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-stated data-memory responder: accept, delay, access, hold response
module dm_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  dm,
    output logic           busy
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    dm_state_t   state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        access_ok;
    logic        wr_en;
    logic [31:0] rd_word;

    assign access_ok = (lat_addr[31:ADDR_W+2] == '0) && be_legal(lat_be, lat_addr[1:0]);
    assign wr_en     = (state == WAIT) && (cnt == 4'd0) && lat_we && access_ok;

    dm_store_array #(.ADDR_W(ADDR_W)) u_store (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .addr  (lat_addr[ADDR_W+1:2]),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            dm.req_ready <= 1'b1;
            dm.rsp_valid <= 1'b0;
            dm.rsp_rdata <= '0;
            dm.rsp_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm.req_valid && dm.req_ready) begin
                        lat_we       <= dm.req_we;
                        lat_addr     <= dm.req_addr;
                        lat_wdata    <= dm.req_wdata;
                        lat_be       <= dm.req_be;
                        cnt          <= WAIT_LOAD;
                        state        <= WAIT;
                        dm.req_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // The store itself lands in the array on this same edge via wr_en.
                        state        <= RESP;
                        dm.rsp_valid <= 1'b1;
                        dm.rsp_err   <= ~access_ok;
                        dm.rsp_rdata <= (access_ok && !lat_we) ? rd_word : '0;
                    end
                end
                RESP: begin
                    if (dm.rsp_ready) begin
                        state        <= IDLE;
                        dm.rsp_valid <= 1'b0;
                        dm.rsp_rdata <= '0;
                        dm.rsp_err   <= 1'b0;
                        dm.req_ready <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dm.req_ready <= 1'b1;
                    dm.rsp_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 builds)
module tb_dm_responder;
    localparam int AW = 10;
    localparam int WA = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy_a, busy_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dm_responder_if a_if ();
    dm_responder_if b_if ();

    dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .dm(a_if.slave), .busy(busy_a));
    dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .dm(b_if.slave), .busy(busy_b));

    logic [31:0] model [1 << AW];
    logic [3:0]  legal_pick [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Legal access = aligned naturally-sized contiguous lane group inside the storage range.
    function automatic logic ref_legal(input logic [31:0] addr, input logic [3:0] be);
        int lanes;
        int low;
        lanes = $countones(be);
        low = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) low = i;
        if (addr >= (32'd4 << AW)) return 1'b0;
        if (!(lanes == 1 || lanes == 2 || lanes == 4)) return 1'b0;
        if (be != 4'(((1 << lanes) - 1) << low)) return 1'b0;
        if ((low % lanes) != 0) return 1'b0;
        return (int'(addr[1:0]) % lanes) == 0;
    endfunction

    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic err, output logic [31:0] rdata);
        int idx;
        idx = int'(addr[AW+1:2]);
        err = 1'b0;
        rdata = '0;
        if (!ref_legal(addr, be)) begin
            err = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            rdata = model[idx];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int hold,
                           input logic exp_err, input logic [31:0] exp_rdata);
        int n;
        int lat;
        a_if.req_valid = 1'b1;
        a_if.req_we    = we;
        a_if.req_addr  = addr;
        a_if.req_wdata = wdata;
        a_if.req_be    = be;
        a_if.rsp_ready = (hold == 0);
        n = 0;
        while (a_if.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk({tag, " accept timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        a_if.req_we    = 1'($urandom);
        a_if.req_addr  = $urandom;
        a_if.req_wdata = $urandom;
        a_if.req_be    = 4'($urandom);
        lat = 0;
        while (a_if.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, 32'(lat), 32'(WA + 1));
        repeat (hold) begin @(posedge clk); #1; end
        chk({tag, " rsp_err"}, 32'(a_if.rsp_err), 32'(exp_err));
        chk({tag, " rsp_rdata"}, a_if.rsp_rdata, exp_rdata);
        a_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " ready/valid after rsp"}, {30'd0, a_if.req_ready, a_if.rsp_valid}, 32'b10);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        logic        rwe;
        logic [31:0] raddr, rwdata;
        logic [3:0]  rbe;

        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0;
        a_if.req_wdata = '0;   a_if.req_be = '0;   a_if.rsp_ready = 1'b1;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0;
        b_if.req_wdata = '0;   b_if.req_be = '0;   b_if.rsp_ready = 1'b1;
        clear_model();

        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h11,   32'h0000AA00, 4'b0010, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADAAEF};
        tbl[4]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,    32'h0,        4'b1111, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h12,   32'h00001234, 4'b0011, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h12,   32'h0,        4'b0011, 1'b0, 32'hDEAD1234};
        tbl[8]  = '{1'b1, 32'h11,   32'h00005555, 4'b0011, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEAD1234};
        tbl[10] = '{1'b0, 32'h11,   32'h0,        4'b1111, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h13,   32'h0,        4'b0101, 1'b1, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(a_if.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        chk("reset rsp_rdata", a_if.rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(a_if.rsp_err), 32'd0);
        chk("reset busy", 32'(busy_a), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", {30'd0, a_if.req_ready, busy_a}, 32'b10);

        for (int i = 0; i < 12; i++) begin
            ref_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, e, r);
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                    i % 2, tbl[i].exp_err, tbl[i].exp_rdata);
        end

        // Backpressure: response held while a competing request is presented.
        a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 32'h10; a_if.req_be = 4'hF;
        a_if.rsp_ready = 1'b0;
        @(posedge clk); #1;
        a_if.req_addr = 32'h0;
        for (int n = 0; n < 50 && a_if.rsp_valid !== 1'b1; n++) begin @(posedge clk); #1; end
        chk("bp first rdata", a_if.rsp_rdata, 32'hDEAD1234);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp_valid", k), 32'(a_if.rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", k), a_if.rsp_rdata, 32'hDEAD1234);
            chk($sformatf("bp%0d busy", k), 32'(busy_a), 32'd1);
            chk($sformatf("bp%0d req_ready", k), 32'(a_if.req_ready), 32'd0);
        end
        a_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        chk("bp release", {29'd0, a_if.req_ready, a_if.rsp_valid, busy_a}, 32'b100);

        // Reset while a store is waiting: store must be dropped.
        a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_addr = 32'h20;
        a_if.req_wdata = 32'h12345678; a_if.req_be = 4'hF;
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid-op busy", 32'(busy_a), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid-op reset outs",
            {27'd0, a_if.req_ready, a_if.rsp_valid, a_if.rsp_err, busy_a, |a_if.rsp_rdata}, 32'b10000);
        @(posedge clk); #2;
        reset = 1'b1;
        clear_model();
        @(posedge clk); #1;
        run_req("after reset load", 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, 32'h0);

        for (int k = 0; k < 60; k++) begin
            rwe    = 1'($urandom_range(0, 1));
            raddr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) raddr[$urandom_range(12, 31)] = 1'b1;
            rwdata = $urandom;
            rbe    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : legal_pick[$urandom_range(0, 6)];
            ref_access(rwe, raddr, rwdata, rbe, e, r);
            run_req($sformatf("rand%0d", k), rwe, raddr, rwdata, rbe, $urandom_range(0, 3), e, r);
        end

        // Zero-wait build: back-to-back requests, accepted every third cycle.
        b_if.req_valid = 1'b1; b_if.req_we = 1'b1; b_if.req_addr = 32'h8;
        b_if.req_wdata = 32'hCAFEF00D; b_if.req_be = 4'hF; b_if.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("w0 req_ready c%0d", i), 32'(b_if.req_ready), 32'(i % 3 == 0));
            chk($sformatf("w0 rsp_valid c%0d", i), 32'(b_if.rsp_valid), 32'(i % 3 == 2));
            if (i % 3 == 2) chk($sformatf("w0 rdata c%0d", i), b_if.rsp_rdata,
                                (i == 2) ? 32'h0 : 32'hCAFEF00D);
            if (i == 1) b_if.req_we = 1'b0;
            @(posedge clk); #1;
        end
        b_if.req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
